// File: rtl/ram_wartend_if.sv
// Load/store bus between the core and ram_wartend: request, write payload and
// the completion pulses, with master (core) and slave (RAM) views.
interface ram_wartend_if #(
    parameter int WORDSIZE = 32
);
    // A request (LesenAn and/or SchreibenAn) is taken when sampled high on a rising
    // edge while Beschaeftigt is low. Beschaeftigt then stays high until the
    // completion edge. Request levels are ignored while Beschaeftigt is high and
    // need not be held after acceptance. Completion is a one-cycle pulse
    // (DatenBereit / DatenGeschrieben, plus Fehler for an out-of-range address).
    logic                  LesenAn;
    logic                  SchreibenAn;
    logic [WORDSIZE/8-1:0] ByteMaske;
    logic [WORDSIZE-1:0]   DatenRein;
    logic [WORDSIZE-1:0]   Adresse;
    logic [WORDSIZE-1:0]   DatenRaus;
    logic                  DatenBereit;
    logic                  DatenGeschrieben;
    logic                  Beschaeftigt;
    logic                  Fehler;

    modport master (
        output LesenAn, SchreibenAn, ByteMaske, DatenRein, Adresse,
        input  DatenRaus, DatenBereit, DatenGeschrieben, Beschaeftigt, Fehler
    );

    modport slave (
        input  LesenAn, SchreibenAn, ByteMaske, DatenRein, Adresse,
        output DatenRaus, DatenBereit, DatenGeschrieben, Beschaeftigt, Fehler
    );
endinterface

// File: rtl/ram_wartend.sv
// Single-port word RAM with programmable wait states, byte-masked writes,
// read-before-write on combined requests and out-of-range flagging.
module ram_wartend #(
    parameter int WORDSIZE    = 32,
    parameter int WORDS       = 32,
    parameter int WARTEZYKLEN = 0
) (
    input  logic        Clock,
    input  logic        Reset,
    ram_wartend_if.slave bus,
    output logic [1:0]  dbg_state
);
    localparam int NB = WORDSIZE / 8;
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        BEREIT = 2'd0,
        WARTEN = 2'd1,
        FERTIG = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  lesen_q, lesen_d;
    logic                  schreiben_q, schreiben_d;
    logic [WORDSIZE-1:0]   adr_q, adr_d;
    logic [WORDSIZE-1:0]   din_q, din_d;
    logic [NB-1:0]         mask_q, mask_d;
    logic [WORDSIZE-1:0]   raus_q, raus_d;
    logic                  bereit_q, bereit_d;
    logic                  geschr_q, geschr_d;
    logic                  fehler_q, fehler_d;

    // Zero at time zero; Reset deliberately leaves the contents alone.
    logic [WORDSIZE-1:0]   mem [WORDS] = '{default: '0};

    logic                  in_range;
    logic [AW-1:0]         idx;
    logic [WORDSIZE-1:0]   rd_word;
    logic [WORDSIZE-1:0]   wr_word;
    logic                  wr_en;

    // Full-width compare so high address bits never alias into the array.
    assign in_range = (adr_q < WORDSIZE'(WORDS));
    assign idx      = adr_q[AW-1:0];
    assign rd_word  = mem[idx];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lesen_d     = lesen_q;
        schreiben_d = schreiben_q;
        adr_d       = adr_q;
        din_d       = din_q;
        mask_d      = mask_q;
        raus_d      = raus_q;
        bereit_d    = 1'b0;
        geschr_d    = 1'b0;
        fehler_d    = 1'b0;
        wr_en       = 1'b0;
        wr_word     = rd_word;
        for (int i = 0; i < NB; i++) begin
            if (mask_q[i]) wr_word[8*i +: 8] = din_q[8*i +: 8];
        end

        case (state_q)
            BEREIT: begin
                if (bus.LesenAn || bus.SchreibenAn) begin
                    lesen_d     = bus.LesenAn;
                    schreiben_d = bus.SchreibenAn;
                    adr_d       = bus.Adresse;
                    din_d       = bus.DatenRein;
                    mask_d      = bus.ByteMaske;
                    cnt_d       = 8'(WARTEZYKLEN);
                    state_d     = (WARTEZYKLEN > 0) ? WARTEN : FERTIG;
                end
            end
            WARTEN: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) state_d = FERTIG;
            end
            FERTIG: begin
                state_d = BEREIT;
                // The read sees the pre-write word, giving read-before-write.
                if (lesen_q) begin
                    raus_d   = in_range ? rd_word : '0;
                    bereit_d = 1'b1;
                end
                if (schreiben_q) begin
                    geschr_d = 1'b1;
                    wr_en    = in_range;
                end
                fehler_d = ~in_range;
            end
            default: state_d = BEREIT;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= BEREIT;
            cnt_q       <= '0;
            lesen_q     <= 1'b0;
            schreiben_q <= 1'b0;
            adr_q       <= '0;
            din_q       <= '0;
            mask_q      <= '0;
            raus_q      <= '0;
            bereit_q    <= 1'b0;
            geschr_q    <= 1'b0;
            fehler_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lesen_q     <= lesen_d;
            schreiben_q <= schreiben_d;
            adr_q       <= adr_d;
            din_q       <= din_d;
            mask_q      <= mask_d;
            raus_q      <= raus_d;
            bereit_q    <= bereit_d;
            geschr_q    <= geschr_d;
            fehler_q    <= fehler_d;
        end
    end

    // A Reset on the completion edge must abort the write too.
    always_ff @(posedge Clock) begin
        if (wr_en && !Reset) mem[idx] <= wr_word;
    end

    assign bus.DatenRaus        = raus_q;
    assign bus.DatenBereit      = bereit_q;
    assign bus.DatenGeschrieben = geschr_q;
    assign bus.Beschaeftigt     = (state_q != BEREIT);
    assign bus.Fehler           = fehler_q;
    assign dbg_state            = state_q;
endmodule
